mux_bank: RTL and testbench
===========================

// Module: mux_bank
// PURPOSE
//  Bank of three independent registered multiplexers: 2:1 x DW_A, 4:1 x DW_B, 8:1 x DW_C.
//  Shared data-path selector block for the transceiver datapath; used for lane/bit selection.
//  Each output registers the selected lane of its packed input bus on every rising clock edge.
// PARAMETERS
//  DW_A  1  lane width of the 2:1 mux (inData211 = 2 lanes)
//  DW_B  4  lane width of the 4:1 mux (inData414 = 4 lanes)
//  DW_C  1  lane width of the 8:1 mux (inData811 = 8 lanes)
// PORTS
//  inClk       in   1        clock, rising edge
//  inRst       in   1        reset, asynchronous, active-high
//  inData211   in   2*DW_A   packed lanes; lane k = inData211[k*DW_A +: DW_A]
//  inSel211    in   1        lane select for 2:1
//  outData211  out  DW_A     selected 2:1 lane, registered
//  inData414   in   4*DW_B   packed lanes; lane k = inData414[k*DW_B +: DW_B]
//  inSel414    in   2        lane select for 4:1
//  outData414  out  DW_B     selected 4:1 lane, registered
//  inData811   in   8*DW_C   packed lanes; lane k = inData811[k*DW_C +: DW_C]
//  inSel811    in   3        lane select for 8:1
//  outData811  out  DW_C     selected 8:1 lane, registered
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - inRst high: all outputs go to 0 immediately, without waiting for a clock edge.
//    Outputs hold 0 while inRst stays high.
//  - inRst low, each rising inClk: outDataXXX <= lane[inSelXXX] of inDataXXX.
//  - Latency: exactly 1 cycle from a data or select change to the output.
//    No combinational path from any input to any output.
//  - Lane 0 occupies the LSBs. Example: inData414 = 16'h00F0 with inSel414 = 1 selects bits [7:4].
//  - Every select code is valid, so no out-of-range case exists.
//    X/Z on a select must not corrupt the other two muxes.
//  - The three muxes are fully independent; simultaneous data and select changes are allowed.
//    Each output reflects the values sampled at the edge.
//  - Reset deasserting mid-stream: the first edge after deassertion loads the current selection.
//  - No handshake and no state machine; the block is pure selection plus an output register.
// CONFIGURATION
//  MUX_BANK_PARITY_EN defined:
//    - Adds output port outParity (out, 1, registered).
//    - outParity = ^{next outData811, outData414, outData211}, i.e. even parity over the values
//      being loaded, so it is coherent with the outputs in the same cycle.
//    - outParity resets to 0 together with the outputs.
//  MUX_BANK_PARITY_EN undefined: port and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - mux_bank_pkg holds the lane-count constants (N211 = 2, N414 = 4, N811 = 8),
//    select-width constants (SEL211_W = 1, SEL414_W = 2, SEL811_W = 3) and default widths.
//  - Sub-module mux_n1 (parameters N, W): combinational N:1 selection, instantiated three times.
//  - The output registers and async reset live in mux_bank.
// TESTING
//  1. inRst = 1 with any inputs -> all outputs 0 with no clock edge.
//     Release inRst -> outputs follow the next edge.
//  2. 2:1 mux:
//     - inData211 = 2'b10, inSel211 = 1 -> outData211 = 1 one cycle later.
//     - inSel211 = 0 -> 0.
//     - inData211 = 2'b01, inSel211 = 0 -> 1.
//  3. 4:1 mux:
//     - inData414 = 16'h00F0, inSel414 = 1 -> outData414 = 4'hF.
//     - inSel414 = 0 -> 4'h0.
//     - inData414 = 16'h000E, inSel414 = 0 -> 4'hE.
//  4. 8:1 mux:
//     - inData811 = 8'h20, inSel811 = 5 -> outData811 = 1.
//     - inSel811 = 4 -> 0.
//     - inData811 = 8'h80, inSel811 = 7 -> 1.
//  5. Sweep every select against walking-one data on all three muxes.
//     Each output must equal the reference model one cycle later.
//     Assert reset mid-sweep -> outputs 0 immediately.
//  6. With MUX_BANK_PARITY_EN: outputs 1, 4'hF, 1 -> outParity = 0 in the same cycle.
//     Outputs 1, 4'h7, 1 -> outParity = 1.

Source files
------------

// File: rtl/mux_bank_pkg.sv
// Shared constants for the mux_bank selector block: lane counts, select widths
// and default lane widths.
package mux_bank_pkg;

  localparam int N211 = 2;
  localparam int N414 = 4;
  localparam int N811 = 8;

  localparam int SEL211_W = 1;
  localparam int SEL414_W = 2;
  localparam int SEL811_W = 3;

  localparam int DW_A_DEF = 1;
  localparam int DW_B_DEF = 4;
  localparam int DW_C_DEF = 1;

  // Select width for an N-lane mux; a single lane still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Combinational N:1 lane selector over a packed bus; lane 0 sits in the LSBs.
module mux_n1 #(
  parameter int N     = 2,
  parameter int W     = 1,
  parameter int SEL_W = 1
) (
  input  logic [N*W-1:0]   data,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y
);

  // Unpacking into an array lets the select index it at its natural width.
  logic [W-1:0] lanes [N];

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lanes[k] = data[k*W +: W];
  end

  assign y = lanes[sel];

endmodule

// File: rtl/mux_bank.sv
// Bank of three independent registered muxes (2:1, 4:1, 8:1).
// Optional registered even-parity output enabled by MUX_BANK_PARITY_EN.
module mux_bank
  import mux_bank_pkg::*;
#(
  parameter int DW_A = DW_A_DEF,
  parameter int DW_B = DW_B_DEF,
  parameter int DW_C = DW_C_DEF
) (
  input  logic                   inClk,
  input  logic                   inRst,
  input  logic [N211*DW_A-1:0]   inData211,
  input  logic [SEL211_W-1:0]    inSel211,
  output logic [DW_A-1:0]        outData211,
  input  logic [N414*DW_B-1:0]   inData414,
  input  logic [SEL414_W-1:0]    inSel414,
  output logic [DW_B-1:0]        outData414,
  input  logic [N811*DW_C-1:0]   inData811,
  input  logic [SEL811_W-1:0]    inSel811,
  output logic [DW_C-1:0]        outData811
`ifdef MUX_BANK_PARITY_EN
  ,
  output logic                   outParity
`endif
);

  logic [DW_A-1:0] next211;
  logic [DW_B-1:0] next414;
  logic [DW_C-1:0] next811;

  mux_n1 #(.N(N211), .W(DW_A), .SEL_W(SEL211_W)) u_mux211 (
    .data (inData211),
    .sel  (inSel211),
    .y    (next211)
  );

  mux_n1 #(.N(N414), .W(DW_B), .SEL_W(SEL414_W)) u_mux414 (
    .data (inData414),
    .sel  (inSel414),
    .y    (next414)
  );

  mux_n1 #(.N(N811), .W(DW_C), .SEL_W(SEL811_W)) u_mux811 (
    .data (inData811),
    .sel  (inSel811),
    .y    (next811)
  );

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      outData211 <= '0;
      outData414 <= '0;
      outData811 <= '0;
    end else begin
      outData211 <= next211;
      outData414 <= next414;
      outData811 <= next811;
    end
  end

`ifdef MUX_BANK_PARITY_EN
  // Parity is taken over the values being loaded so it lines up with the outputs.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      outParity <= 1'b0;
    end else begin
      outParity <= ^{next811, next414, next211};
    end
  end
`endif

endmodule

// File: tb/tb_mux_bank.sv
// Self-checking bench for mux_bank: directed vector table, reset sequences,
// walking-one sweep and randomized cycles against a lane-shift reference model.
module tb_mux_bank;

  localparam int DWA = 1;
  localparam int DWB = 4;
  localparam int DWC = 1;

  logic        inClk = 1'b0;
  logic        inRst;
  logic [1:0]  inData211;
  logic        inSel211;
  logic [15:0] inData414;
  logic [1:0]  inSel414;
  logic [7:0]  inData811;
  logic [2:0]  inSel811;
  logic        outData211;
  logic [3:0]  outData414;
  logic        outData811;
`ifdef MUX_BANK_PARITY_EN
  logic        outParity;
`endif

  int compared   = 0;
  int mismatched = 0;

  mux_bank #(.DW_A(DWA), .DW_B(DWB), .DW_C(DWC)) dut (
    .inClk      (inClk),
    .inRst      (inRst),
    .inData211  (inData211),
    .inSel211   (inSel211),
    .outData211 (outData211),
    .inData414  (inData414),
    .inSel414   (inSel414),
    .outData414 (outData414),
    .inData811  (inData811),
    .inSel811   (inSel811),
    .outData811 (outData811)
`ifdef MUX_BANK_PARITY_EN
    ,
    .outParity  (outParity)
`endif
  );

  always #5 inClk = ~inClk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0]  d211;
    logic        s211;
    logic [15:0] d414;
    logic [1:0]  s414;
    logic [7:0]  d811;
    logic [2:0]  s811;
    logic        e211;
    logic [3:0]  e414;
    logic        e811;
  } vec_t;

  vec_t vecs[6];

  // Reference: lane k of a bus is the W bits starting at k*W.
  function automatic logic [31:0] laneOf(input logic [63:0] bus, input int sel, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((bus >> (sel * w)) & mask);
  endfunction

  task automatic applyStimulus(input logic [1:0] d211, input logic s211,
                               input logic [15:0] d414, input logic [1:0] s414,
                               input logic [7:0] d811, input logic [2:0] s811);
    inData211 = d211;
    inSel211  = s211;
    inData414 = d414;
    inSel414  = s414;
    inData811 = d811;
    inSel811  = s811;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic e211, input logic [3:0] e414, input logic e811);
    checkOutput({tag, " out211"}, 32'(outData211), 32'(e211));
    checkOutput({tag, " out414"}, 32'(outData414), 32'(e414));
    checkOutput({tag, " out811"}, 32'(outData811), 32'(e811));
  endtask

  task automatic checkModel(input string tag);
    logic        m211;
    logic [3:0]  m414;
    logic        m811;
    m211 = laneOf(64'(inData211), int'(inSel211), DWA) != 0;
    m414 = 4'(laneOf(64'(inData414), int'(inSel414), DWB));
    m811 = laneOf(64'(inData811), int'(inSel811), DWC) != 0;
    tick();
    checkAll(tag, m211, m414, m811);
`ifdef MUX_BANK_PARITY_EN
    checkOutput({tag, " parity"}, 32'(outParity),
                32'(($countones({m811, m414, m211}) % 2) == 1));
`endif
  endtask

  initial begin
    vecs[0] = '{2'b10, 1'b1, 16'h00F0, 2'd1, 8'h20, 3'd5, 1'b1, 4'hF, 1'b1};
    vecs[1] = '{2'b10, 1'b0, 16'h00F0, 2'd0, 8'h20, 3'd4, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{2'b01, 1'b0, 16'h000E, 2'd0, 8'h80, 3'd7, 1'b1, 4'hE, 1'b1};
    vecs[3] = '{2'b01, 1'b1, 16'hABCD, 2'd3, 8'h01, 3'd0, 1'b0, 4'hA, 1'b1};
    vecs[4] = '{2'b11, 1'b1, 16'hABCD, 2'd2, 8'hFE, 3'd0, 1'b1, 4'hB, 1'b0};
    vecs[5] = '{2'b00, 1'b0, 16'hABCD, 2'd1, 8'h7F, 3'd7, 1'b0, 4'hC, 1'b0};

    // Async reset with non-zero selections and no clock edge in between.
    inRst = 1'b0;
    applyStimulus(2'b11, 1'b1, 16'hFFFF, 2'd3, 8'hFF, 3'd7);
    tick();
    tick();
    checkAll("pre-reset", 1'b1, 4'hF, 1'b1);
    inRst = 1'b1;
    #2;
    checkAll("async reset", 1'b0, 4'h0, 1'b0);
`ifdef MUX_BANK_PARITY_EN
    checkOutput("async reset parity", 32'(outParity), 32'd0);
`endif
    tick();
    checkAll("reset held", 1'b0, 4'h0, 1'b0);
    #2;
    inRst = 1'b0;
    #1;
    checkAll("after release no edge", 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("first edge after release", 1'b1, 4'hF, 1'b1);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].d211, vecs[i].s211, vecs[i].d414, vecs[i].s414,
                    vecs[i].d811, vecs[i].s811);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].e211, vecs[i].e414, vecs[i].e811);
    end

    // Outputs must not move before the edge when inputs change.
    applyStimulus(vecs[0].d211, vecs[0].s211, vecs[0].d414, vecs[0].s414,
                  vecs[0].d811, vecs[0].s811);
    #1;
    checkAll("latency hold", vecs[5].e211, vecs[5].e414, vecs[5].e811);
    tick();
    checkAll("latency load", vecs[0].e211, vecs[0].e414, vecs[0].e811);

    // An unknown select on one mux leaves the other two intact.
    applyStimulus(2'b10, 1'b1, 16'h5A00, 2'd2, 8'h00, 3'bxxx);
    tick();
    checkOutput("xsel out211", 32'(outData211), 32'd1);
    checkOutput("xsel out414", 32'(outData414), 32'hA);

    // Walking-one sweep over every select/position pair, reset mid-sweep.
    for (int idx = 0; idx < 64; idx++) begin
      applyStimulus(2'(2'b01 << ((idx / 2) % 2)), 1'(idx % 2),
                    16'(16'h0001 << (idx / 4)), 2'(idx % 4),
                    8'(8'h01 << (idx / 8)), 3'(idx % 8));
      if (idx == 30) begin
        tick();
        inRst = 1'b1;
        #2;
        checkAll("sweep reset", 1'b0, 4'h0, 1'b0);
        #1;
        inRst = 1'b0;
      end
      checkModel($sformatf("sweep%0d", idx));
    end

    // Randomized cycles.
    for (int r = 0; r < 200; r++) begin
      applyStimulus(2'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
                    8'($urandom), 3'($urandom));
      checkModel($sformatf("rand%0d", r));
    end

`ifdef MUX_BANK_PARITY_EN
    applyStimulus(2'b01, 1'b0, 16'h000F, 2'd0, 8'h01, 3'd0);
    tick();
    checkAll("par even", 1'b1, 4'hF, 1'b1);
    checkOutput("par even parity", 32'(outParity), 32'd0);
    applyStimulus(2'b01, 1'b0, 16'h0007, 2'd0, 8'h01, 3'd0);
    tick();
    checkAll("par odd", 1'b1, 4'h7, 1'b1);
    checkOutput("par odd parity", 32'(outParity), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
